// File: rtl/vend_ctrl_if.sv
// Vending controller bus: coin acceptor, selection buttons,
// dispenser handshake and the status/change outputs.
interface vend_ctrl_if #(
    parameter int CREDIT_W = 4
) ();
    logic [1:0]          i_coin;
    logic                i_sel_a;
    logic                i_sel_b;
    logic                i_cancel;
    logic                i_disp_ack;
    logic                o_disp_req;
    logic                o_disp_item;
    logic                o_change_pulse;
    logic [CREDIT_W-1:0] o_credit;
    logic                o_coin_reject;
    logic                o_short_credit;
    logic                o_disp_fault;
    logic                o_busy;

    modport master (
        output i_coin, i_sel_a, i_sel_b, i_cancel, i_disp_ack,
        input  o_disp_req, o_disp_item, o_change_pulse, o_credit,
        input  o_coin_reject, o_short_credit, o_disp_fault, o_busy
    );

    modport slave (
        input  i_coin, i_sel_a, i_sel_b, i_cancel, i_disp_ack,
        output o_disp_req, o_disp_item, o_change_pulse, o_credit,
        output o_coin_reject, o_short_credit, o_disp_fault, o_busy
    );
endinterface

// File: rtl/vend_ctrl.sv
// Two-product vending transaction controller: credit accumulation,
// selection, dispenser req/ack sequencing and unit-by-unit change.
module vend_ctrl #(
    parameter int CREDIT_W     = 4,
    parameter int MAX_CREDIT   = 15,
    parameter int PRICE_A      = 3,
    parameter int PRICE_B      = 4,
    parameter int DISP_TIMEOUT = 16
) (
    input logic        clk,
    input logic        rst,
    vend_ctrl_if.slave bus
);
    localparam int CNT_W = $clog2(DISP_TIMEOUT);
    localparam int SUM_W = CREDIT_W + 3;

    localparam logic [CREDIT_W-1:0] P_A      = CREDIT_W'(PRICE_A);
    localparam logic [CREDIT_W-1:0] P_B      = CREDIT_W'(PRICE_B);
    localparam logic [SUM_W-1:0]    MAX_S    = SUM_W'(MAX_CREDIT);
    localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(DISP_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CREDIT,
        S_DISPENSE,
        S_CHANGE
    } state_t;

    state_t              r_state, w_state;
    logic [CREDIT_W-1:0] r_credit, w_credit;
    logic [CNT_W-1:0]    r_cnt, w_cnt;
    logic                r_item, w_item;
    logic                r_req, w_req;
    logic                r_change, w_change;
    logic                r_reject, w_reject;
    logic                r_short, w_short;
    logic                r_fault, w_fault;
    logic                r_busy, w_busy;

    logic [2:0]          w_coin_val;
    logic [SUM_W-1:0]    w_sum;
    logic [CREDIT_W-1:0] w_item_price;
    logic                w_taken;

    // Decode coin code to credit units and form the unwrapped sum
    always_comb begin
        w_coin_val = 3'd0;
        unique case (bus.i_coin)
            2'b01:   w_coin_val = 3'd1;
            2'b10:   w_coin_val = 3'd2;
            2'b11:   w_coin_val = 3'd5;
            default: w_coin_val = 3'd0;
        endcase
        w_sum        = SUM_W'(r_credit) + SUM_W'(w_coin_val);
        w_item_price = r_item ? P_B : P_A;
    end

    // Next-state and next-output logic
    always_comb begin
        w_state  = r_state;
        w_credit = r_credit;
        w_cnt    = r_cnt;
        w_item   = r_item;
        w_req    = r_req;
        w_change = 1'b0;
        w_reject = 1'b0;
        w_short  = 1'b0;
        w_fault  = 1'b0;
        w_taken  = 1'b0;

        unique case (r_state)
            S_IDLE, S_CREDIT: begin
                if (bus.i_cancel && r_state == S_CREDIT) begin
                    w_state = S_CHANGE;
                    w_taken = 1'b1;
                end else if (bus.i_sel_a) begin
                    if (r_credit >= P_A) begin
                        w_credit = r_credit - P_A;
                        w_item   = 1'b0;
                        w_req    = 1'b1;
                        w_cnt    = '0;
                        w_state  = S_DISPENSE;
                        w_taken  = 1'b1;
                    end else begin
                        w_short = 1'b1;
                    end
                end else if (bus.i_sel_b) begin
                    if (r_credit >= P_B) begin
                        w_credit = r_credit - P_B;
                        w_item   = 1'b1;
                        w_req    = 1'b1;
                        w_cnt    = '0;
                        w_state  = S_DISPENSE;
                        w_taken  = 1'b1;
                    end else begin
                        w_short = 1'b1;
                    end
                end
                if (w_coin_val != 3'd0) begin
                    if (w_taken || w_sum > MAX_S) begin
                        w_reject = 1'b1;
                    end else begin
                        w_credit = w_sum[CREDIT_W-1:0];
                        w_state  = S_CREDIT;
                    end
                end
            end
            S_DISPENSE: begin
                w_reject = (w_coin_val != 3'd0);
                if (bus.i_disp_ack) begin
                    w_req   = 1'b0;
                    w_state = (r_credit != '0) ? S_CHANGE : S_IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_req    = 1'b0;
                    w_credit = r_credit + w_item_price;
                    w_fault  = 1'b1;
                    w_state  = S_CHANGE;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            S_CHANGE: begin
                w_reject = (w_coin_val != 3'd0);
                if (r_credit != '0) begin
                    w_change = 1'b1;
                    w_credit = r_credit - CREDIT_W'(1);
                    if (r_credit == CREDIT_W'(1)) begin
                        w_state = S_IDLE;
                    end
                end else begin
                    w_state = S_IDLE;
                end
            end
            default: w_state = S_IDLE;
        endcase

        w_busy = (w_state == S_DISPENSE) || (w_state == S_CHANGE);
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_credit <= '0;
            r_cnt    <= '0;
            r_item   <= 1'b0;
            r_req    <= 1'b0;
            r_change <= 1'b0;
            r_reject <= 1'b0;
            r_short  <= 1'b0;
            r_fault  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_credit <= w_credit;
            r_cnt    <= w_cnt;
            r_item   <= w_item;
            r_req    <= w_req;
            r_change <= w_change;
            r_reject <= w_reject;
            r_short  <= w_short;
            r_fault  <= w_fault;
            r_busy   <= w_busy;
        end
    end

    assign bus.o_disp_req     = r_req;
    assign bus.o_disp_item    = r_item;
    assign bus.o_change_pulse = r_change;
    assign bus.o_credit       = r_credit;
    assign bus.o_coin_reject  = r_reject;
    assign bus.o_short_credit = r_short;
    assign bus.o_disp_fault   = r_fault;
    assign bus.o_busy         = r_busy;
endmodule
